// File: rtl/neopixel_strand_ctrl_gen2.sv
// Double-buffered WS2812/SK6812 strand driver.
// Host loads a back buffer; send snapshots it to a front buffer and serialises it.
module neopixel_strand_ctrl_gen2 #(
  parameter int NUM_PIXELS   = 5,
  parameter int RGBW         = 0,
  parameter int T1H          = 35,
  parameter int T1L          = 30,
  parameter int T0H          = 18,
  parameter int T0L          = 40,
  parameter int LATCH_CYCLES = 2500,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_color,
  input  logic [1:0]    color_index,
  input  logic [7:0]    color_level,
  input  logic [PW-1:0] pixel_index,
  input  logic          send_it,
  output logic          neo_data,
  output logic          ready_to_load,
  output logic          ready_to_send,
  output logic          begin_send,
  output logic          done_send,
  output logic          done_wait
);

  localparam int CH = (RGBW != 0) ? 4 : 3;
  localparam int NB = NUM_PIXELS * CH * 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int M1 = (T1H > T1L) ? T1H : T1L;
  localparam int M0 = (T0H > T0L) ? T0H : T0L;
  localparam int M2 = (M1 > M0) ? M1 : M0;
  localparam int MX = (M2 > LATCH_CYCLES) ? M2 : LATCH_CYCLES;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t        state;
  logic [NB-1:0] back;
  logic [NB-1:0] front;
  logic [BW-1:0] idx;
  logic [BW-1:0] idx_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] t_hi;
  logic [CW-1:0] t_lo;
  logic          cur;
  logic          rdy;
  logic          wr_ok;
  logic [1:0]    slot;
  logic [7:0]    lvl_rev;
  int            base;

  // Buffers hold bits in wire order: bit k of the frame sits at index k.
  always_comb begin
    unique case (color_index)
      2'd0:    slot = 2'd1;
      2'd1:    slot = 2'd2;
      2'd2:    slot = 2'd0;
      default: slot = 2'd3;
    endcase
    for (int i = 0; i < 8; i++) lvl_rev[i] = color_level[7-i];
    base  = (int'(pixel_index) * CH + int'(slot)) * 8;
    wr_ok = load_color
         && (int'(pixel_index) < NUM_PIXELS)
         && ((color_index != 2'd3) || (RGBW != 0));
  end

  always_comb begin
    idx_nx = idx + 1'b1;
    t_hi   = cur ? CW'(T1H - 1) : CW'(T0H - 1);
    t_lo   = cur ? CW'(T1L - 1) : CW'(T0L - 1);
  end

  assign ready_to_load = rdy;
  assign ready_to_send = rdy && (state == IDLE);
  assign begin_send    = rdy && (state == IDLE) && send_it;
  assign done_send     = (state == LOW) && (cnt == t_lo)
                      && (idx == BW'(NB - 1));
  assign done_wait     = (state == LATCH)
                      && (cnt == CW'(LATCH_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      back <= '0;
    end else if (wr_ok) begin
      back[base +: 8] <= lvl_rev;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      front    <= '0;
      idx      <= '0;
      cnt      <= '0;
      cur      <= 1'b0;
      rdy      <= 1'b0;
      neo_data <= 1'b0;
    end else begin
      rdy <= 1'b1;
      unique case (state)
        IDLE: begin
          neo_data <= 1'b0;
          if (begin_send) begin
            front    <= back;
            idx      <= '0;
            cnt      <= '0;
            cur      <= back[0];
            neo_data <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (cnt == t_hi) begin
            cnt      <= '0;
            neo_data <= 1'b0;
            state    <= LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt == t_lo) begin
            cnt <= '0;
            if (idx == BW'(NB - 1)) begin
              state <= LATCH;
            end else begin
              idx      <= idx_nx;
              cur      <= front[idx_nx];
              neo_data <= 1'b1;
              state    <= HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          if (cnt == CW'(LATCH_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_strand_ctrl_gen2.sv
// Directed bench for neopixel_strand_ctrl_gen2: GRB and GRBW
// instances, pulse-width capture per frame, hand-computed timing.
module tb_neopixel_strand_ctrl_gen2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sel = 1'b0;
  logic       load = 1'b0;
  logic       send = 1'b0;
  logic [1:0] ci = '0;
  logic [7:0] lvl = '0;
  logic [7:0] pix = '0;

  logic nd_a, rtl_a, rts_a, bs_a, ds_a, dw_a;
  logic nd_b, rtl_b, rts_b, bs_b, ds_b, dw_b;
  logic nd, rtl, rts, bs, ds, dw;

  always #5 clock = ~clock;

  assign nd  = sel ? nd_b  : nd_a;
  assign rtl = sel ? rtl_b : rtl_a;
  assign rts = sel ? rts_b : rts_a;
  assign bs  = sel ? bs_b  : bs_a;
  assign ds  = sel ? ds_b  : ds_a;
  assign dw  = sel ? dw_b  : dw_a;

  neopixel_strand_ctrl_gen2 dut_a (
    .clock(clock), .reset_n(reset_n),
    .load_color(load & ~sel), .color_index(ci),
    .color_level(lvl), .pixel_index(pix[2:0]),
    .send_it(send & ~sel), .neo_data(nd_a),
    .ready_to_load(rtl_a), .ready_to_send(rts_a),
    .begin_send(bs_a), .done_send(ds_a), .done_wait(dw_a)
  );

  neopixel_strand_ctrl_gen2 #(.NUM_PIXELS(2), .RGBW(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .load_color(load & sel), .color_index(ci),
    .color_level(lvl), .pixel_index(pix[0:0]),
    .send_it(send & sel), .neo_data(nd_b),
    .ready_to_load(rtl_b), .ready_to_send(rts_b),
    .begin_send(bs_b), .done_send(ds_b), .done_wait(dw_b)
  );

  int total = 0;
  int bad = 0;
  int hi[256];
  int lo[256];
  int nb, ones, shape_bad, tds, tdw, bsc, rts_hi;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic s, input logic [7:0] p,
                         input logic [1:0] c, input logic [7:0] l);
    @(negedge clock);
    sel = s; pix = p; ci = c; lvl = l; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Cycle c counts from the begin_send cycle (c=0).
  task automatic frame(input int maxc, input bit poke, input int ld_at);
    int c;
    logic prev;
    nb = 0; ones = 0; shape_bad = 0; tds = -1; tdw = -1;
    bsc = 0; rts_hi = 0; prev = 1'b0;
    @(negedge clock);
    send = 1'b1;
    #1;
    chk("begin_send", int'(bs), 1);
    @(negedge clock);
    c = 1;
    while (tdw < 0 && c <= maxc) begin
      send = poke && (c == 5 || c == 40 || c == 7200);
      load = (c == ld_at);
      #1;
      if (bs) bsc++;
      if (rts) rts_hi++;
      if (nd) begin
        if (!prev && nb < 256) begin
          hi[nb] = 0; lo[nb] = 0; nb++;
        end
        if (nb > 0) hi[nb-1]++;
      end else if (nb > 0 && tds < 0) begin
        lo[nb-1]++;
      end
      if (ds) tds = c;
      if (dw) tdw = c;
      prev = nd;
      c++;
      @(negedge clock);
    end
    send = 1'b0;
    load = 1'b0;
    #1;
    chk("rts_after_frame", int'(rts), 1);
    for (int i = 0; i < nb; i++) begin
      if (hi[i] == 35 && lo[i] == 30) ones++;
      else if (!(hi[i] == 18 && lo[i] == 40)) shape_bad++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_neo", int'(nd), 0);
    chk("rst_rtl", int'(rtl), 0);
    chk("rst_rts", int'(rts), 0);
    chk("rst_begin", int'(bs), 0);
    chk("rst_done_send", int'(ds), 0);
    chk("rst_done_wait", int'(dw), 0);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rel_rtl", int'(rtl), 1);
    chk("rel_rts", int'(rts), 1);

    frame(12000, 1'b0, -1);
    chk("f1_nbits", nb, 120);
    chk("f1_ones", ones, 0);
    chk("f1_shape", shape_bad, 0);
    chk("f1_done_send", tds, 6960);
    chk("f1_latch", tdw - tds, 2500);
    chk("f1_rts_busy", rts_hi, 0);

    do_load(1'b0, 8'd0, 2'd2, 8'h80);
    frame(12000, 1'b0, -1);
    chk("f2_ones", ones, 1);
    chk("f2_hi0", hi[0], 35);
    chk("f2_lo0", lo[0], 30);
    chk("f2_shape", shape_bad, 0);
    chk("f2_done_send", tds, 6967);

    sel = 1'b0; pix = 8'd4; ci = 2'd0; lvl = 8'hFF;
    frame(12000, 1'b0, 100);
    chk("fa_ones", ones, 1);
    chk("fa_done_send", tds, 6967);

    frame(12000, 1'b0, -1);
    chk("fb_ones", ones, 9);
    chk("fb_hi103", hi[103], 18);
    chk("fb_hi104", hi[104], 35);
    chk("fb_hi111", hi[111], 35);
    chk("fb_hi112", hi[112], 18);
    chk("fb_done_send", tds, 7023);

    do_load(1'b0, 8'd1, 2'd3, 8'hFF);
    do_load(1'b0, 8'd5, 2'd2, 8'hFF);
    frame(12000, 1'b1, -1);
    chk("poke_begin", bsc, 0);
    chk("poke_rts", rts_hi, 0);
    chk("poke_nbits", nb, 120);
    chk("ign_ones", ones, 9);
    chk("poke_done_send", tds, 7023);

    do_load(1'b1, 8'd1, 2'd3, 8'h01);
    frame(12000, 1'b0, -1);
    chk("w_nbits", nb, 64);
    chk("w_ones", ones, 1);
    chk("w_hi63", hi[63], 35);
    chk("w_shape", shape_bad, 0);
    chk("w_done_send", tds, 3719);
    chk("w_latch", tdw - tds, 2500);

    sel = 1'b0;
    @(negedge clock);
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    repeat (2909) @(negedge clock);
    #1;
    chk("mid_high", int'(nd), 1);
    reset_n = 1'b0;
    #1;
    chk("async_neo", int'(nd), 0);
    chk("async_rts", int'(rts), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("post_rst_rts", int'(rts), 1);
    frame(12000, 1'b0, -1);
    chk("pr_nbits", nb, 120);
    chk("pr_ones", ones, 0);
    chk("pr_done_send", tds, 6960);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
